// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, NOP encoding and IF/ID control codes for the fetch stage
package fetch_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int DEF_PC_W   = 16;
    localparam int DEF_INST_W = DATA_W;

    localparam logic [DEF_INST_W-1:0] NOP = 16'h0000;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_BUBBLE = 2'b10
    } ifid_op_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold (stall) and bubble (flush) controls
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        i_op,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_pc1,
    output logic [INST_W-1:0] o_inst,
    output logic              o_valid
);

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pc1;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    // A bubble only clears VALID/INST; PC fields keep their last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc    <= '0;
            r_pc1   <= '0;
            r_inst  <= INST_W'(NOP);
            r_valid <= 1'b0;
        end else begin
            case (ifid_op_t'(i_op))
                IFID_LOAD: begin
                    r_pc    <= i_pc;
                    r_pc1   <= i_pc + PC_W'(1);
                    r_inst  <= i_inst;
                    r_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    r_inst  <= INST_W'(NOP);
                    r_valid <= 1'b0;
                end
                default: begin
                    r_pc    <= r_pc;
                    r_pc1   <= r_pc1;
                    r_inst  <= r_inst;
                    r_valid <= r_valid;
                end
            endcase
        end
    end

    assign o_pc    = r_pc;
    assign o_pc1   = r_pc1;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction-memory request, skid buffer and branch discard logic
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [PC_W-1:0]   BR_TARGET,
    output logic              IMEM_REQ,
    output logic [PC_W-1:0]   IMEM_ADDR,
    input  logic              IMEM_READY,
    input  logic [INST_W-1:0] IMEM_DATA,
    output logic [PC_W-1:0]   ID_PC,
    output logic [PC_W-1:0]   ID_PC1,
    output logic [INST_W-1:0] ID_INST,
    output logic              ID_VALID
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_target;
    logic              r_buf_valid;
    logic [PC_W-1:0]   r_buf_pc;
    logic [INST_W-1:0] r_buf_inst;

    state_t            w_state_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_target_nxt;
    logic              w_buf_valid_nxt;
    logic [PC_W-1:0]   w_buf_pc_nxt;
    logic [INST_W-1:0] w_buf_inst_nxt;
    logic [1:0]        w_ifid_op;
    logic [PC_W-1:0]   w_ifid_pc;
    logic [INST_W-1:0] w_ifid_inst;
    logic              w_beat;

    // A full buffer blocks new requests, so it can never overflow.
    assign IMEM_REQ  = !RST && (!r_buf_valid || (r_state == ST_DISCARD));
    assign IMEM_ADDR = r_pc;
    assign w_beat    = IMEM_REQ && IMEM_READY;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_target_nxt    = r_target;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_pc_nxt    = r_buf_pc;
        w_buf_inst_nxt  = r_buf_inst;
        w_ifid_op       = IFID_HOLD;
        w_ifid_pc       = r_pc;
        w_ifid_inst     = IMEM_DATA;

        case (r_state)
            ST_RUN: begin
                if (BR_TAKEN && !STALL) begin
                    w_ifid_op       = IFID_BUBBLE;
                    w_buf_valid_nxt = 1'b0;
                    // A request in flight must complete at its old address before redirecting.
                    if (IMEM_REQ && !IMEM_READY) begin
                        w_target_nxt = BR_TARGET;
                        w_state_nxt  = ST_DISCARD;
                    end else begin
                        w_pc_nxt = BR_TARGET;
                    end
                end else if (STALL) begin
                    if (w_beat) begin
                        w_buf_valid_nxt = 1'b1;
                        w_buf_pc_nxt    = r_pc;
                        w_buf_inst_nxt  = IMEM_DATA;
                        w_pc_nxt        = r_pc + PC_W'(1);
                    end
                end else if (r_buf_valid) begin
                    w_ifid_op       = IFID_LOAD;
                    w_ifid_pc       = r_buf_pc;
                    w_ifid_inst     = r_buf_inst;
                    w_buf_valid_nxt = 1'b0;
                end else if (w_beat) begin
                    w_ifid_op = IFID_LOAD;
                    w_pc_nxt  = r_pc + PC_W'(1);
                end else begin
                    w_ifid_op = IFID_BUBBLE;
                end
            end
            ST_DISCARD: begin
                w_ifid_op = IFID_BUBBLE;
                if (IMEM_READY) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_target    <= RESET_PC;
            r_buf_valid <= 1'b0;
            r_buf_pc    <= '0;
            r_buf_inst  <= INST_W'(NOP);
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_target    <= w_target_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_buf_inst  <= w_buf_inst_nxt;
        end
    end

    fetch_stage_if_id_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .CLK     (CLK),
        .RST     (RST),
        .i_op    (w_ifid_op),
        .i_pc    (w_ifid_pc),
        .i_inst  (w_ifid_inst),
        .o_pc    (ID_PC),
        .o_pc1   (ID_PC1),
        .o_inst  (ID_INST),
        .o_valid (ID_VALID)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL;
    logic        BR_TAKEN;
    logic [15:0] BR_TARGET;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_READY;
    logic [15:0] IMEM_DATA;
    logic [15:0] ID_PC;
    logic [15:0] ID_PC1;
    logic [15:0] ID_INST;
    logic        ID_VALID;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.PC_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STALL      (STALL),
        .BR_TAKEN   (BR_TAKEN),
        .BR_TARGET  (BR_TARGET),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_READY (IMEM_READY),
        .IMEM_DATA  (IMEM_DATA),
        .ID_PC      (ID_PC),
        .ID_PC1     (ID_PC1),
        .ID_INST    (ID_INST),
        .ID_VALID   (ID_VALID)
    );

    always #5 CLK = ~CLK;

    // Memory image: every word holds its own address scrambled.
    assign IMEM_DATA = IMEM_ADDR ^ 16'hA5A5;

    function automatic logic [48:0] exp_id(input logic [15:0] p);
        return {1'b1, p, p + 16'd1, p ^ 16'hA5A5};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 16'h0; IMEM_READY = 1'b1;
        tick(); tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== 49'h0) begin
            n_fail++; $display("FAIL reset_id: got %h want 0", {ID_VALID, ID_PC, ID_PC1, ID_INST});
        end
        n_tests++;
        if (IMEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", IMEM_REQ);
        end
        RST = 1'b0; #1;
        n_tests++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL reset_first_req: got %b/%h want 1/0000", IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_stream();
        IMEM_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'(i))) begin
                n_fail++; $display("FAIL stream_id[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'(i)));
            end
            n_tests++;
            if (IMEM_ADDR !== 16'(i + 1)) begin
                n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, IMEM_ADDR, 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'd4)) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'd4));
            end
            n_tests++;
            if ({IMEM_REQ, IMEM_ADDR} !== {1'b0, 16'd6}) begin
                n_fail++; $display("FAIL stall_req[%0d]: got %b/%h want 0/0006", i, IMEM_REQ, IMEM_ADDR);
            end
        end
        STALL = 1'b0;
        tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'd5)) begin
            n_fail++; $display("FAIL stall_drain: got %h want %h", {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'd5));
        end
        n_tests++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 16'd6}) begin
            n_fail++; $display("FAIL stall_rereq: got %b/%h want 1/0006", IMEM_REQ, IMEM_ADDR);
        end
        tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'd6)) begin
            n_fail++; $display("FAIL stall_next: got %h want %h", {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'd6));
        end
    endtask

    task automatic test_branch();
        BR_TAKEN = 1'b1; BR_TARGET = 16'h0040;
        tick();
        BR_TAKEN = 1'b0;
        n_tests++;
        if ({ID_VALID, ID_INST, IMEM_ADDR} !== {17'h0, 16'h0040}) begin
            n_fail++; $display("FAIL branch_bubble: got %b/%h/%h want 0/0000/0040", ID_VALID, ID_INST, IMEM_ADDR);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'(16'h40 + i))) begin
                n_fail++; $display("FAIL branch_target[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'(16'h40 + i)));
            end
        end
    endtask

    task automatic test_branch_wait();
        IMEM_READY = 1'b0; BR_TAKEN = 1'b1; BR_TARGET = 16'h0080;
        for (int i = 0; i < 2; i++) begin
            tick();
            BR_TAKEN = 1'b0;
            n_tests++;
            if ({ID_VALID, ID_INST, IMEM_REQ, IMEM_ADDR} !== {17'h0, 1'b1, 16'h0042}) begin
                n_fail++; $display("FAIL bwait_hold[%0d]: got %b/%h/%b/%h want 0/0000/1/0042", i, ID_VALID, ID_INST, IMEM_REQ, IMEM_ADDR);
            end
        end
        IMEM_READY = 1'b1;
        tick();
        n_tests++;
        if ({ID_VALID, ID_INST, IMEM_ADDR} !== {17'h0, 16'h0080}) begin
            n_fail++; $display("FAIL bwait_drop: got %b/%h/%h want 0/0000/0080", ID_VALID, ID_INST, IMEM_ADDR);
        end
        tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'h0080)) begin
            n_fail++; $display("FAIL bwait_target: got %h want %h", {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'h0080));
        end
    endtask

    task automatic test_stall_branch();
        STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h00C0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'h0080)) begin
                n_fail++; $display("FAIL sbr_hold[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'h0080));
            end
        end
        STALL = 1'b0;
        tick();
        BR_TAKEN = 1'b0;
        n_tests++;
        if ({ID_VALID, ID_INST, IMEM_REQ, IMEM_ADDR} !== {17'h0, 1'b1, 16'h00C0}) begin
            n_fail++; $display("FAIL sbr_redirect: got %b/%h/%b/%h want 0/0000/1/00c0", ID_VALID, ID_INST, IMEM_REQ, IMEM_ADDR);
        end
        tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'h00C0)) begin
            n_fail++; $display("FAIL sbr_target: got %h want %h", {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'h00C0));
        end
    endtask

    task automatic test_reset_mid();
        IMEM_READY = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        n_tests++;
        if ({ID_VALID, ID_PC, ID_PC1, ID_INST, IMEM_REQ} !== 50'h0) begin
            n_fail++; $display("FAIL rmid_wait: got %h/%b want 0/0", {ID_VALID, ID_PC, ID_PC1, ID_INST}, IMEM_REQ);
        end
        RST = 1'b0; IMEM_READY = 1'b1; #1;
        n_tests++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL rmid_restart: got %b/%h want 1/0000", IMEM_REQ, IMEM_ADDR);
        end
        tick();
        STALL = 1'b1;
        tick();
        n_tests++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b0, 16'h0002}) begin
            n_fail++; $display("FAIL rmid_full: got %b/%h want 0/0002", IMEM_REQ, IMEM_ADDR);
        end
        RST = 1'b1; STALL = 1'b0;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'(i))) begin
                n_fail++; $display("FAIL rmid_stream[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'(i)));
            end
        end
    endtask

    task automatic test_wrap();
        BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFE;
        tick();
        BR_TAKEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(16'(32'hFFFE + i))) begin
                n_fail++; $display("FAIL wrap_id[%0d]: got %h want %h", i, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(16'(32'hFFFE + i)));
            end
            if (i == 1) begin
                n_tests++;
                if (IMEM_ADDR !== 16'h0000) begin
                    n_fail++; $display("FAIL wrap_addr: got %h want 0000", IMEM_ADDR);
                end
            end
        end
    endtask

    // Architectural check: valid instructions reaching ID must follow program
    // order (sequential, or the target of the last accepted redirect).
    task automatic test_random();
        logic [15:0] exp_next;
        logic [15:0] prev_addr;
        logic [48:0] old_id;
        logic        discard;
        logic        prev_wait;
        logic        req, st, br, rdy;
        logic [15:0] tgt;
        int          delivered;
        RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0;
        tick();
        RST = 1'b0;
        exp_next = 16'h0; discard = 1'b0; prev_wait = 1'b0; prev_addr = 16'h0; delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            STALL      = ($urandom_range(0, 9) < 3);
            IMEM_READY = ($urandom_range(0, 9) < 6);
            BR_TAKEN   = ($urandom_range(0, 9) == 0);
            BR_TARGET  = 16'($urandom);
            #1;
            if (prev_wait) begin
                n_tests++;
                if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, prev_addr}) begin
                    n_fail++; $display("FAIL rnd_addr_stable[%0d]: got %b/%h want 1/%h", c, IMEM_REQ, IMEM_ADDR, prev_addr);
                end
            end
            req = IMEM_REQ; st = STALL; br = BR_TAKEN; rdy = IMEM_READY; tgt = BR_TARGET;
            prev_addr = IMEM_ADDR;
            prev_wait = req && !rdy;
            old_id = {ID_VALID, ID_PC, ID_PC1, ID_INST};
            tick();
            n_tests++;
            if (discard || (br && !st)) begin
                if ({ID_VALID, ID_INST} !== 17'h0) begin
                    n_fail++; $display("FAIL rnd_bubble[%0d]: got %b/%h want 0/0000", c, ID_VALID, ID_INST);
                end
                if (discard) begin
                    if (rdy) discard = 1'b0;
                end else begin
                    exp_next = tgt;
                    discard  = req && !rdy;
                end
            end else if (st) begin
                if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== old_id) begin
                    n_fail++; $display("FAIL rnd_stall_hold[%0d]: got %h want %h", c, {ID_VALID, ID_PC, ID_PC1, ID_INST}, old_id);
                end
            end else if (ID_VALID) begin
                if ({ID_VALID, ID_PC, ID_PC1, ID_INST} !== exp_id(exp_next)) begin
                    n_fail++; $display("FAIL rnd_order[%0d]: got %h want %h", c, {ID_VALID, ID_PC, ID_PC1, ID_INST}, exp_id(exp_next));
                end
                exp_next = exp_next + 16'd1;
                delivered++;
            end else begin
                if (ID_INST !== 16'h0000) begin
                    n_fail++; $display("FAIL rnd_nop[%0d]: got %h want 0000", c, ID_INST);
                end
            end
        end
        n_tests++;
        if (delivered < 200) begin
            n_fail++; $display("FAIL rnd_progress: got %0d delivered want >= 200", delivered);
        end
        STALL = 1'b0; BR_TAKEN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_wait();
        test_stall_branch();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
